text_console_writer: RTL and testbench
======================================

// Module: text_console_writer
// PURPOSE
//  Terminal-style writer for the 80x30 text RAM that the GPU scans out. The CPU writes one byte to an IO
//  register; the block interprets it as a printable char or control code, manages the cursor, and performs
//  line wrap, scroll-up and clear-screen by driving the text RAM write port and a second read port.
// PARAMETERS
//  COLS       80      characters per row
//  ROWS       30      rows per screen; RAM cells used = COLS*ROWS (2400)
//  BASE_ADDR  12'h081 IO address of CHAR register; STATUS=BASE+1, COL=BASE+2, ROW=BASE+3
// PORTS
//  clk          in   1   system clock; all ports synchronous to it
//  rst          in   1   asynchronous, active-high reset
//  din          in   8   IO write data
//  address      in   12  IO address
//  io_w_en      in   1   IO write strobe (one cycle)
//  io_r_en      in   1   IO read strobe (one cycle)
//  dout         out  8   IO read data, registered, valid cycle after io_r_en
//  busy         out  1   high while a multi-cycle operation (scroll/clear/tab) runs
//  ram_w_en     out  1   text RAM write enable
//  ram_w_addr   out  12  text RAM write address (row*COLS+col)
//  ram_w_data   out  8   text RAM write data
//  ram_r_addr   out  12  text RAM read address (scroll source)
//  ram_r_data   in   8   text RAM read data, 1-cycle latency after ram_r_addr
// BEHAVIOUR
//  Reset: col=0,row=0, state IDLE, busy=0, ram_w_en=0, ram_w_addr=0, ram_w_data=0, ram_r_addr=0, dout=0.
//   RAM contents are not cleared by reset. Reset mid-scroll/clear aborts; RAM left partially updated.
//  States: IDLE, SCROLL, FILL (scroll last-row blanking), CLEAR, TAB.
//  CHAR write (io_w_en, address==BASE) in IDLE at cycle t; effects registered at t+1:
//   0x20..0x7E: ram_w_en=1, addr=row*COLS+col, data=din; col+1. Back-to-back writes each cycle legal.
//   0x0D CR: col=0.  0x0A LF: col=0, row+1.  0x08 BS: if col>0 {col-1; write 0x20 at new col} else no-op.
//   0x0C FF: -> CLEAR. Any other code: ignored, no RAM write.
//  Wrap: col advancing past COLS-1 -> col=0, row+1.
//  row advancing past ROWS-1 -> row stays ROWS-1, enter SCROLL (busy=1 from t+1).
//  SCROLL: pipelined copy, one cell/cycle: ram_r_addr=i+COLS at cycle k, ram_w_addr=i,data=ram_r_data at k+1,
//   i=0..(ROWS-1)*COLS-1; then FILL writes 0x20 to row ROWS-1 (COLS cycles); then IDLE, busy=0.
//  CLEAR: writes 0x20 to addr 0..COLS*ROWS-1, one per cycle; then col=0,row=0, IDLE.
//  Write to CHAR while busy: dropped, no state change (software polls STATUS.busy).
//  Addresses never exceed COLS*ROWS-1; ram_w_en low in any cycle without a RAM write.
//  IO read (t -> dout at t+1): STATUS={busy,7'd0}; COL={1'b0,col}; ROW={3'b0,row}; other address: dout held.
//  IO write to COL/ROW in IDLE sets cursor; values >=COLS / >=ROWS are clamped to COLS-1 / ROWS-1.
//  Simultaneous io_w_en and io_r_en: both honoured.
// CONFIGURATION
//  TEXT_CONSOLE_TAB_EN defined: 0x09 enters TAB, writes 0x20 and advances col one cell/cycle until col is a
//   multiple of 8 (at least one cell); wrap/scroll rules apply; busy=1 during TAB.
//  Undefined: 0x09 ignored like other non-printables; TAB state not built.
// TESTING
//  Reset, write 0x41 to 0x081 -> next cycle ram_w_en=1, addr=0, data=0x41; COL read returns 1.
//  80 writes of 0x42 from (0,0) -> last at addr 79; cursor (0,1); 81st char lands at addr 80.
//  Set ROW=29,COL=79, write 0x43 -> write addr 2399, busy rises, 2320 copy writes (src=dst+80), then 80
//   writes of 0x20 at 2320..2399, busy falls; cursor (0,29); writes during busy produce no RAM writes.
//  Write 0x0C -> 2400 writes of 0x20 at 0..2399 in order; cursor (0,0); busy high exactly 2400 cycles.
//  At col=0 write 0x08 -> no RAM write; at col=5 -> write 0x20 at addr row*80+4, col=4.
//  TEXT_CONSOLE_TAB_EN: col=3, write 0x09 -> spaces at cols 3..7, col=8; at col=8 -> cols 8..15, col=16.

Source files
------------

// File: rtl/text_console_writer.sv
// Terminal-style writer for the scanned-out text RAM: printable chars, CR/LF/BS/FF, wrap, scroll, clear.
// Optional TEXT_CONSOLE_TAB_EN builds the TAB state (0x09 pads with spaces to the next multiple of 8).
module text_console_writer #(
  parameter int          COLS      = 80,
  parameter int          ROWS      = 30,
  parameter logic [11:0] BASE_ADDR = 12'h081
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  din,
  input  logic [11:0] address,
  input  logic        io_w_en,
  input  logic        io_r_en,
  output logic [7:0]  dout,
  output logic        busy,
  output logic        ram_w_en,
  output logic [11:0] ram_w_addr,
  output logic [7:0]  ram_w_data,
  output logic [11:0] ram_r_addr,
  input  logic [7:0]  ram_r_data
);

  localparam logic [2:0]  S_IDLE   = 3'd0;
  localparam logic [2:0]  S_SCROLL = 3'd1;
  localparam logic [2:0]  S_FILL   = 3'd2;
  localparam logic [2:0]  S_CLEAR  = 3'd3;
`ifdef TEXT_CONSOLE_TAB_EN
  localparam logic [2:0]  S_TAB    = 3'd4;
`endif

  localparam logic [11:0] LP_COLS  = 12'(COLS);
  localparam logic [11:0] LP_TOTAL = 12'(COLS * ROWS);
  localparam logic [11:0] LP_LAST  = 12'(COLS * ROWS - 1);
  localparam logic [11:0] A_STATUS = BASE_ADDR + 12'd1;
  localparam logic [11:0] A_COL    = BASE_ADDR + 12'd2;
  localparam logic [11:0] A_ROW    = BASE_ADDR + 12'd3;

  logic [2:0]  r_state;
  logic [6:0]  r_col;
  logic [4:0]  r_row;
  logic [11:0] r_idx;
  logic        r_ram_w_en;
  logic [11:0] r_ram_w_addr;
  logic [7:0]  r_ram_w_data;
  logic        r_copy;
  logic [11:0] r_ram_r_addr;
  logic [7:0]  r_dout;

  logic [11:0] w_cur_addr;
  logic        w_wrap;
  logic        w_last_row;
  logic [6:0]  w_adv_col;
  logic [4:0]  w_adv_row;
  logic        w_printable;

  assign w_cur_addr  = {7'd0, r_row} * LP_COLS + {5'd0, r_col};
  assign w_wrap      = (r_col == 7'(COLS - 1));
  assign w_last_row  = (r_row == 5'(ROWS - 1));
  assign w_adv_col   = w_wrap ? 7'd0 : r_col + 7'd1;
  assign w_adv_row   = (w_wrap && !w_last_row) ? r_row + 5'd1 : r_row;
  assign w_printable = (din >= 8'h20) && (din <= 8'h7E);

  assign busy       = (r_state != S_IDLE);
  assign ram_w_en   = r_ram_w_en;
  assign ram_w_addr = r_ram_w_addr;
  // Copy writes forward the RAM read data in the cycle it arrives, keeping one cell per cycle.
  assign ram_w_data = r_copy ? ram_r_data : r_ram_w_data;
  assign ram_r_addr = r_ram_r_addr;
  assign dout       = r_dout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_col        <= 7'd0;
      r_row        <= 5'd0;
      r_idx        <= 12'd0;
      r_ram_w_en   <= 1'b0;
      r_ram_w_addr <= 12'd0;
      r_ram_w_data <= 8'd0;
      r_copy       <= 1'b0;
      r_ram_r_addr <= 12'd0;
      r_dout       <= 8'd0;
    end else begin
      r_ram_w_en <= 1'b0;
      r_copy     <= 1'b0;

      if (io_r_en) begin
        if (address == A_STATUS)   r_dout <= {busy, 7'd0};
        else if (address == A_COL) r_dout <= {1'b0, r_col};
        else if (address == A_ROW) r_dout <= {3'b0, r_row};
      end

      case (r_state)
        S_IDLE: begin
          if (io_w_en) begin
            if (address == BASE_ADDR) begin
              if (w_printable) begin
                r_ram_w_en   <= 1'b1;
                r_ram_w_addr <= w_cur_addr;
                r_ram_w_data <= din;
                r_col        <= w_adv_col;
                r_row        <= w_adv_row;
                if (w_wrap && w_last_row) begin
                  r_state      <= S_SCROLL;
                  r_ram_r_addr <= LP_COLS;
                end
              end else if (din == 8'h0D) begin
                r_col <= 7'd0;
              end else if (din == 8'h0A) begin
                r_col <= 7'd0;
                if (w_last_row) begin
                  r_state      <= S_SCROLL;
                  r_ram_r_addr <= LP_COLS;
                end else begin
                  r_row <= r_row + 5'd1;
                end
              end else if (din == 8'h08) begin
                if (r_col != 7'd0) begin
                  r_col        <= r_col - 7'd1;
                  r_ram_w_en   <= 1'b1;
                  r_ram_w_addr <= w_cur_addr - 12'd1;
                  r_ram_w_data <= 8'h20;
                end
              end else if (din == 8'h0C) begin
                r_ram_w_en   <= 1'b1;
                r_ram_w_addr <= 12'd0;
                r_ram_w_data <= 8'h20;
                r_idx        <= 12'd1;
                r_state      <= S_CLEAR;
`ifdef TEXT_CONSOLE_TAB_EN
              end else if (din == 8'h09) begin
                r_ram_w_en   <= 1'b1;
                r_ram_w_addr <= w_cur_addr;
                r_ram_w_data <= 8'h20;
                r_col        <= w_adv_col;
                r_row        <= w_adv_row;
                if (w_wrap && w_last_row) begin
                  r_state      <= S_SCROLL;
                  r_ram_r_addr <= LP_COLS;
                end else if (w_adv_col[2:0] != 3'd0) begin
                  r_state <= S_TAB;
                end
`endif
              end
            end else if (address == A_COL) begin
              r_col <= (din >= 8'(COLS)) ? 7'(COLS - 1) : din[6:0];
            end else if (address == A_ROW) begin
              r_row <= (din >= 8'(ROWS)) ? 5'(ROWS - 1) : din[4:0];
            end
          end
        end
`ifdef TEXT_CONSOLE_TAB_EN
        S_TAB: begin
          r_ram_w_en   <= 1'b1;
          r_ram_w_addr <= w_cur_addr;
          r_ram_w_data <= 8'h20;
          r_col        <= w_adv_col;
          r_row        <= w_adv_row;
          if (w_wrap && w_last_row) begin
            r_state      <= S_SCROLL;
            r_ram_r_addr <= LP_COLS;
          end else if (w_adv_col[2:0] == 3'd0) begin
            r_state <= S_IDLE;
          end
        end
`endif
        // Read address leads the write address by one row; the destination is the previous source minus COLS.
        S_SCROLL: begin
          r_ram_w_en   <= 1'b1;
          r_copy       <= 1'b1;
          r_ram_w_addr <= r_ram_r_addr - LP_COLS;
          if (r_ram_r_addr == LP_LAST) begin
            r_state <= S_FILL;
            r_idx   <= LP_TOTAL - LP_COLS;
          end else begin
            r_ram_r_addr <= r_ram_r_addr + 12'd1;
          end
        end
        S_FILL: begin
          r_ram_w_en   <= 1'b1;
          r_ram_w_addr <= r_idx;
          r_ram_w_data <= 8'h20;
          if (r_idx == LP_LAST) r_state <= S_IDLE;
          else                  r_idx   <= r_idx + 12'd1;
        end
        S_CLEAR: begin
          if (r_idx == LP_TOTAL) begin
            r_state <= S_IDLE;
            r_col   <= 7'd0;
            r_row   <= 5'd0;
          end else begin
            r_ram_w_en   <= 1'b1;
            r_ram_w_addr <= r_idx;
            r_ram_w_data <= 8'h20;
            r_idx        <= r_idx + 12'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer with a behavioural synchronous text RAM.
module tb_text_console_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  din;
  logic [11:0] address;
  logic        io_w_en;
  logic        io_r_en;
  logic [7:0]  dout;
  logic        busy;
  logic        ram_w_en;
  logic [11:0] ram_w_addr;
  logic [7:0]  ram_w_data;
  logic [11:0] ram_r_addr;
  logic [7:0]  ram_r_data;

  logic [7:0]  mem  [0:2399];
  logic [7:0]  snap [0:2319];

  int n_checks = 0;
  int n_errors = 0;

  text_console_writer dut (
    .clk(clk), .rst(rst), .din(din), .address(address),
    .io_w_en(io_w_en), .io_r_en(io_r_en), .dout(dout), .busy(busy),
    .ram_w_en(ram_w_en), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
    .ram_r_addr(ram_r_addr), .ram_r_data(ram_r_data)
  );

  always #5 clk = ~clk;

  // Text RAM: seeded with a pattern while rst is high, 1-cycle read latency.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2400; i++) mem[i] <= 8'(i) ^ 8'hA5;
      ram_r_data <= 8'd0;
    end else begin
      if (ram_w_en) mem[ram_w_addr] <= ram_w_data;
      ram_r_data <= mem[ram_r_addr];
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic io_write(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    address = a; din = d; io_w_en = 1'b1;
    @(negedge clk);
    io_w_en = 1'b0;
  endtask

  task automatic io_read(input logic [11:0] a, output logic [7:0] d);
    @(negedge clk);
    address = a; io_r_en = 1'b1;
    @(negedge clk);
    io_r_en = 1'b0;
    d = dout;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst = 1'b1; din = 8'd0; address = 12'd0; io_w_en = 1'b0; io_r_en = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_checks++; if (ram_w_en !== 1'b0) begin n_errors++; $display("FAIL reset_w_en: got %0b want 0", ram_w_en); end
    n_checks++; if (ram_w_addr !== 12'd0) begin n_errors++; $display("FAIL reset_w_addr: got %0d want 0", ram_w_addr); end
    n_checks++; if (ram_w_data !== 8'd0) begin n_errors++; $display("FAIL reset_w_data: got %0h want 0", ram_w_data); end
    n_checks++; if (ram_r_addr !== 12'd0) begin n_errors++; $display("FAIL reset_r_addr: got %0d want 0", ram_r_addr); end
    n_checks++; if (dout !== 8'd0) begin n_errors++; $display("FAIL reset_dout: got %0h want 0", dout); end
    rst = 1'b0;
    io_read(12'h083, v);
    n_checks++; if (v !== 8'd0) begin n_errors++; $display("FAIL reset_col: got %0d want 0", v); end
    io_read(12'h084, v);
    n_checks++; if (v !== 8'd0) begin n_errors++; $display("FAIL reset_row: got %0d want 0", v); end
  endtask

  task automatic test_char();
    logic [7:0] v;
    io_write(12'h081, 8'h41);
    n_checks++; if (ram_w_en !== 1'b1) begin n_errors++; $display("FAIL char_w_en: got %0b want 1", ram_w_en); end
    n_checks++; if (ram_w_addr !== 12'd0) begin n_errors++; $display("FAIL char_addr: got %0d want 0", ram_w_addr); end
    n_checks++; if (ram_w_data !== 8'h41) begin n_errors++; $display("FAIL char_data: got %0h want 41", ram_w_data); end
    @(negedge clk);
    n_checks++; if (ram_w_en !== 1'b0) begin n_errors++; $display("FAIL char_w_en_drop: got %0b want 0", ram_w_en); end
    io_read(12'h083, v);
    n_checks++; if (v !== 8'd1) begin n_errors++; $display("FAIL char_col: got %0d want 1", v); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    @(negedge clk);
    address = 12'h081; din = 8'h61; io_w_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (ram_w_en !== 1'b1 || ram_w_addr !== 12'(i + 1) || ram_w_data !== 8'(8'h61 + i)) begin
        n_errors++;
        $display("FAIL b2b_%0d: got en=%0b addr=%0d data=%0h want en=1 addr=%0d data=%0h",
                 i, ram_w_en, ram_w_addr, ram_w_data, i + 1, 8'h61 + i);
      end
      din = 8'(8'h62 + i);
    end
    io_w_en = 1'b0;
    io_read(12'h083, v);
    n_checks++; if (v !== 8'd4) begin n_errors++; $display("FAIL b2b_col: got %0d want 4", v); end
  endtask

  task automatic test_wrap();
    logic [7:0] v;
    int bad;
    bad = 0;
    io_write(12'h083, 8'd0);
    io_write(12'h084, 8'd0);
    for (int i = 0; i < 80; i++) begin
      io_write(12'h081, 8'h42);
      if (ram_w_en !== 1'b1 || ram_w_addr !== 12'(i) || ram_w_data !== 8'h42) bad++;
    end
    n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL wrap_row0_writes: got %0d bad writes want 0", bad); end
    io_read(12'h083, v);
    n_checks++; if (v !== 8'd0) begin n_errors++; $display("FAIL wrap_col: got %0d want 0", v); end
    io_read(12'h084, v);
    n_checks++; if (v !== 8'd1) begin n_errors++; $display("FAIL wrap_row: got %0d want 1", v); end
    io_write(12'h081, 8'h44);
    n_checks++; if (ram_w_en !== 1'b1 || ram_w_addr !== 12'd80) begin
      n_errors++; $display("FAIL wrap_81st: got en=%0b addr=%0d want en=1 addr=80", ram_w_en, ram_w_addr);
    end
  endtask

  task automatic test_control();
    logic [7:0] v;
    io_write(12'h083, 8'd10);
    io_write(12'h081, 8'h0D);
    n_checks++; if (ram_w_en !== 1'b0) begin n_errors++; $display("FAIL cr_no_write: got en=%0b want 0", ram_w_en); end
    io_read(12'h083, v);
    n_checks++; if (v !== 8'd0) begin n_errors++; $display("FAIL cr_col: got %0d want 0", v); end
    io_write(12'h083, 8'd6);
    io_write(12'h081, 8'h0A);
    io_read(12'h084, v);
    n_checks++; if (v !== 8'd2) begin n_errors++; $display("FAIL lf_row: got %0d want 2", v); end
    io_read(12'h083, v);
    n_checks++; if (v !== 8'd0) begin n_errors++; $display("FAIL lf_col: got %0d want 0", v); end
    io_write(12'h083, 8'd7);
    io_write(12'h081, 8'h01);
    n_checks++; if (ram_w_en !== 1'b0) begin n_errors++; $display("FAIL ignored_no_write: got en=%0b want 0", ram_w_en); end
`ifndef TEXT_CONSOLE_TAB_EN
    io_write(12'h081, 8'h09);
    n_checks++; if (ram_w_en !== 1'b0 || busy !== 1'b0) begin
      n_errors++; $display("FAIL tab_ignored: got en=%0b busy=%0b want 0 0", ram_w_en, busy);
    end
`endif
    io_read(12'h083, v);
    n_checks++; if (v !== 8'd7) begin n_errors++; $display("FAIL ignored_col: got %0d want 7", v); end
    io_write(12'h083, 8'd200);
    io_read(12'h083, v);
    n_checks++; if (v !== 8'd79) begin n_errors++; $display("FAIL clamp_col: got %0d want 79", v); end
    io_write(12'h084, 8'd40);
    io_read(12'h084, v);
    n_checks++; if (v !== 8'd29) begin n_errors++; $display("FAIL clamp_row: got %0d want 29", v); end
  endtask

  task automatic test_backspace();
    logic [7:0] v;
    io_write(12'h084, 8'd3);
    io_write(12'h083, 8'd0);
    io_write(12'h081, 8'h08);
    n_checks++; if (ram_w_en !== 1'b0) begin n_errors++; $display("FAIL bs_col0_write: got en=%0b want 0", ram_w_en); end
    io_read(12'h083, v);
    n_checks++; if (v !== 8'd0) begin n_errors++; $display("FAIL bs_col0_col: got %0d want 0", v); end
    io_write(12'h083, 8'd5);
    io_write(12'h081, 8'h08);
    n_checks++; if (ram_w_en !== 1'b1 || ram_w_addr !== 12'd244 || ram_w_data !== 8'h20) begin
      n_errors++; $display("FAIL bs_write: got en=%0b addr=%0d data=%0h want 1 244 20", ram_w_en, ram_w_addr, ram_w_data);
    end
    io_read(12'h083, v);
    n_checks++; if (v !== 8'd4) begin n_errors++; $display("FAIL bs_col: got %0d want 4", v); end
  endtask

`ifdef TEXT_CONSOLE_TAB_EN
  task automatic test_tab();
    logic [7:0] v;
    int cnt, first, last, bad;
    io_write(12'h084, 8'd2);
    io_write(12'h083, 8'd3);
    for (int pass = 0; pass < 2; pass++) begin
      io_write(12'h081, 8'h09);
      cnt = 0; first = -1; last = -1; bad = 0;
      for (int i = 0; i < 50; i++) begin
        if (ram_w_en === 1'b1) begin
          if (cnt == 0) first = int'(ram_w_addr);
          last = int'(ram_w_addr);
          if (ram_w_data !== 8'h20) bad++;
          cnt++;
        end
        if (ram_w_en !== 1'b1 && busy !== 1'b1) break;
        @(negedge clk);
      end
      n_checks++;
      if (cnt != (pass == 0 ? 5 : 8) || first != (pass == 0 ? 163 : 168) ||
          last != (pass == 0 ? 167 : 175) || bad != 0) begin
        n_errors++;
        $display("FAIL tab_%0d: got cnt=%0d first=%0d last=%0d bad=%0d want %0d %0d %0d 0", pass, cnt, first, last, bad,
                 pass == 0 ? 5 : 8, pass == 0 ? 163 : 168, pass == 0 ? 167 : 175);
      end
      io_read(12'h083, v);
      n_checks++; if (v !== (pass == 0 ? 8'd8 : 8'd16)) begin
        n_errors++; $display("FAIL tab_col_%0d: got %0d want %0d", pass, v, pass == 0 ? 8 : 16);
      end
    end
  endtask
`endif

  task automatic test_scroll();
    logic [7:0] v, exp;
    int k, bad, first_bad;
    bit done, status_ok;
    io_write(12'h084, 8'd29);
    io_write(12'h083, 8'd79);
    io_write(12'h081, 8'h43);
    n_checks++; if (ram_w_en !== 1'b1 || ram_w_addr !== 12'd2399 || ram_w_data !== 8'h43 || busy !== 1'b1) begin
      n_errors++; $display("FAIL scroll_entry: got en=%0b addr=%0d data=%0h busy=%0b want 1 2399 43 1",
                           ram_w_en, ram_w_addr, ram_w_data, busy);
    end
    for (int j = 0; j < 2320; j++) snap[j] = mem[j + 80];
    snap[2319] = 8'h43;
    k = 0; bad = 0; first_bad = -1; done = 1'b0; status_ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      io_w_en = 1'b0; io_r_en = 1'b0;
      if (ram_w_en === 1'b1) begin
        exp = (k < 2320) ? snap[k] : 8'h20;
        if (ram_w_addr !== 12'(k) || ram_w_data !== exp) begin
          if (first_bad < 0) first_bad = k;
          bad++;
        end
        k++;
      end
      if (i == 201) status_ok = (dout === 8'h80);
      if (busy !== 1'b1) begin done = 1'b1; break; end
      if (i == 100) begin address = 12'h081; din = 8'h55; io_w_en = 1'b1; end
      if (i == 200) begin address = 12'h082; io_r_en = 1'b1; end
    end
    n_checks++; if (!done) begin n_errors++; $display("FAIL scroll_done: busy still high after 3000 cycles"); end
    n_checks++; if (k != 2400) begin n_errors++; $display("FAIL scroll_count: got %0d writes want 2400", k); end
    n_checks++; if (bad != 0) begin n_errors++; $display("FAIL scroll_data: got %0d bad writes (first at %0d) want 0", bad, first_bad); end
    n_checks++; if (!status_ok) begin n_errors++; $display("FAIL scroll_status: busy bit not read as 80"); end
    io_read(12'h083, v);
    n_checks++; if (v !== 8'd0) begin n_errors++; $display("FAIL scroll_col: got %0d want 0", v); end
    io_read(12'h084, v);
    n_checks++; if (v !== 8'd29) begin n_errors++; $display("FAIL scroll_row: got %0d want 29", v); end
  endtask

  task automatic test_clear();
    logic [7:0] v;
    int k, bad, bcnt;
    bit done;
    io_write(12'h083, 8'd12);
    io_write(12'h081, 8'h0C);
    k = 0; bad = 0; bcnt = 0; done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (ram_w_en === 1'b1) begin
        if (ram_w_addr !== 12'(k) || ram_w_data !== 8'h20) bad++;
        k++;
      end
      if (busy === 1'b1) bcnt++;
      else begin done = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++; if (!done) begin n_errors++; $display("FAIL clear_done: busy still high after 3000 cycles"); end
    n_checks++; if (k != 2400) begin n_errors++; $display("FAIL clear_count: got %0d writes want 2400", k); end
    n_checks++; if (bad != 0) begin n_errors++; $display("FAIL clear_data: got %0d bad writes want 0", bad); end
    n_checks++; if (bcnt != 2400) begin n_errors++; $display("FAIL clear_busy: got %0d busy cycles want 2400", bcnt); end
    io_read(12'h083, v);
    n_checks++; if (v !== 8'd0) begin n_errors++; $display("FAIL clear_col: got %0d want 0", v); end
    io_read(12'h084, v);
    n_checks++; if (v !== 8'd0) begin n_errors++; $display("FAIL clear_row: got %0d want 0", v); end
  endtask

  initial begin
    test_reset();
    test_char();
    test_back_to_back();
    test_wrap();
    test_control();
    test_backspace();
`ifdef TEXT_CONSOLE_TAB_EN
    test_tab();
`endif
    test_scroll();
    test_clear();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
